// File: rtl/float_to_fixed_if.sv
// Bus bundle between the float_to_fixed denormaliser and its producer and consumer.
// The slave modport is the block's view. The master modport is the driving environment's view.
interface float_to_fixed_if #(
    parameter int MW = 4,
    parameter int EW = 2
);
    // Valid/ready handshake on both sides. A transfer happens on a rising clk
    // edge where valid and ready are both 1. The producer keeps valid and its
    // data steady until that edge. The block never makes a ready depend on a
    // valid in the same cycle.
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] F;
    logic [EW-1:0] P;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] _D;
    logic          nonnorm;
    logic [1:0]    dbg_state;

    modport slave (
        input  in_valid, F, P, out_ready,
        output in_ready, out_valid, _D, nonnorm, dbg_state
    );

    modport master (
        output in_valid, F, P, out_ready,
        input  in_ready, out_valid, _D, nonnorm, dbg_state
    );
endinterface

// File: rtl/float_to_fixed.sv
// Serial denormaliser: rebuilds D = F >> P one bit per clock.
// The result is driven active-low on _D.
module float_to_fixed #(
    parameter int MW = 4,
    parameter int EW = 2
) (
    input  logic             clk,
    input  logic             rst,
    float_to_fixed_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [EW-1:0] MAX_P = '1;

    state_e        state_q, state_d;
    logic [MW-1:0] sr_q, sr_d;
    logic [EW-1:0] cnt_q, cnt_d;
    logic          nonnorm_q, nonnorm_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            nonnorm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            nonnorm_q <= nonnorm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        nonnorm_d = nonnorm_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d      = bus.F;
                    cnt_d     = bus.P;
                    // The all-max exponent with a missing leading one is the normaliser's clamp, not an error.
                    nonnorm_d = !bus.F[MW-1] && (bus.F != '0) && (bus.P != MAX_P);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    sr_d  = sr_q >> 1;
                    cnt_d = cnt_q - EW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus._D        = ~sr_q;
    assign bus.nonnorm   = nonnorm_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_float_to_fixed.sv
// Testbench for float_to_fixed. It runs directed cases with literal expectations,
// then a normaliser round trip and random traffic against a cycle-level behavioural model.
module tb_float_to_fixed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_to_fixed_if #(.MW(4), .EW(2)) ifc ();

  float_to_fixed #(.MW(4), .EW(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int n_sent      = 0;
  int n_done      = 0;
  int n_discard   = 0;
  int cyc         = 0;

  logic rand_mode = 1'b0;
  logic ready_man = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out_ready is driven from this process only
  always @(posedge clk) begin
    #1;
    ifc.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_man;
  end

  always @(posedge clk) cyc++;

  // behavioural model: one transaction in flight, result = F >> P after P+1 cycles
  logic [4:0] exp_q[$];
  int   due      = 0;
  bit   seen     = 0;
  bit   busy     = 0;
  bit   rst_pend = 1;

  always @(negedge clk) begin
    logic [3:0] exp_nd;
    if (rst_pend) begin
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_D", 32'(ifc._D), 32'hf);
      chk("rst_nonnorm", 32'(ifc.nonnorm), 32'd0);
    end else begin
      chk("in_ready", 32'(ifc.in_ready), 32'(!busy));
      if (exp_q.size() != 0) begin
        if (!seen && cyc == due) seen = 1;
        chk("out_valid", 32'(ifc.out_valid), 32'(seen));
        if (seen) begin
          exp_nd = ~exp_q[0][3:0];
          chk("model_D", 32'(ifc._D), 32'(exp_nd));
          chk("model_nonnorm", 32'(ifc.nonnorm), 32'(exp_q[0][4]));
        end
      end else begin
        chk("out_valid_idle", 32'(ifc.out_valid), 32'd0);
      end
    end
    rst_pend = rst;
    if (rst) begin
      if (exp_q.size() != 0) n_discard++;
      exp_q.delete();
      busy = 0;
      seen = 0;
    end else if (exp_q.size() != 0 && seen && ifc.out_ready) begin
      void'(exp_q.pop_front());
      busy = 0;
      n_done++;
    end else if (!busy && ifc.in_valid) begin
      logic nn;
      nn = (ifc.F < 4'd8) && (ifc.F != 4'd0) && (ifc.P != 2'd3);
      exp_q.push_back({nn, 4'(ifc.F >> ifc.P)});
      due  = cyc + int'(ifc.P) + 2;
      seen = 0;
      busy = 1;
    end
  end

  // all tasks start and end at posedge+2
  task automatic send(input logic [3:0] f, input logic [1:0] p);
    int   n;
    logic acc;
    ifc.in_valid = 1'b1;
    ifc.F = f;
    ifc.P = p;
    n = 0;
    do begin
      acc = ifc.in_ready;
      @(posedge clk); #2;
      n++;
    end while (!acc && n < 60);
    ifc.in_valid = 1'b0;
    if (acc) n_sent++;
    else begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_valid(output int lat, output logic ok);
    lat = 0;
    while (!ifc.out_valid && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    ok = ifc.out_valid;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL valid_timeout: out_valid 0 after %0d cycles, expected 1", lat);
    end
  endtask

  task automatic drain();
    int n;
    ready_man = 1'b1;
    n = 0;
    while (ifc.out_valid && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    ready_man = 1'b0;
    chk("drain", 32'(ifc.out_valid), 32'd0);
  endtask

  task automatic get(input logic [3:0] exp_nd, input logic exp_nn, input int exp_lat,
                     input string name);
    int   lat;
    logic ok;
    wait_valid(lat, ok);
    if (ok) begin
      chk({name, "_D"}, 32'(ifc._D), 32'(exp_nd));
      chk({name, "_nonnorm"}, 32'(ifc.nonnorm), 32'(exp_nn));
      if (exp_lat >= 0) chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    end
    drain();
  endtask

  function automatic void normalise(input logic [3:0] d, output logic [3:0] f,
                                    output logic [1:0] p);
    f = d;
    p = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!f[3]) begin
        f = f << 1;
        p = p + 2'd1;
      end
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] f;
    logic [1:0] p;
    int         lat;
    logic       ok;
    ifc.in_valid = 1'b0;
    ifc.F = 4'd0;
    ifc.P = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;

    // reset in the middle of a shift
    send(4'b1000, 2'd3);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_D", 32'(ifc._D), 32'hf);
    chk("midrst_nonnorm", 32'(ifc.nonnorm), 32'd0);

    send(4'b1010, 2'd1);
    get(4'b1010, 1'b0, 2, "basic");
    chk("basic_idle", 32'(ifc.in_ready), 32'd1);

    // max shift, then a stall with a new request that must be ignored
    send(4'b1000, 2'd3);
    wait_valid(lat, ok);
    chk("max_latency", 32'(lat), 32'd4);
    chk("max_D", 32'(ifc._D), 32'b1110);
    ifc.in_valid = 1'b1;
    ifc.F = 4'b1100;
    ifc.P = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("stall_D", 32'(ifc._D), 32'b1110);
      chk("stall_out_valid", 32'(ifc.out_valid), 32'd1);
      chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
    end
    ifc.in_valid = 1'b0;
    drain();

    send(4'b1110, 2'd0);
    get(4'b0001, 1'b0, 1, "zero_shift");
    send(4'b0100, 2'd3);
    get(4'b1111, 1'b0, 4, "clamp");
    send(4'b0110, 2'd1);
    get(4'b1100, 1'b1, 2, "nonnorm");
    send(4'b0000, 2'd2);
    get(4'b1111, 1'b0, 3, "zero");

    // round trip through a normaliser model under random out_ready
    rand_mode = 1'b1;
    for (int d = 0; d < 16; d++) begin
      normalise(4'(d), f, p);
      send(f, p);
      get(~4'(d), 1'b0, -1, "round_trip");
    end

    // random traffic with random gaps, checked by the model
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #2;
      end
      send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (ifc.out_valid) drain();
    repeat (3) @(posedge clk);
    #2;
    chk("no_lost_txn", 32'(n_done + n_discard), 32'(n_sent));
    chk("final_idle", 32'(ifc.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
